reg_native_arbiter: RTL and testbench
=====================================

// Module: reg_native_arbiter
// PURPOSE
//  Shares one downstream reg_native_if between NUM_MST upstream masters, e.g. an APB regmst and a debug master
//  driving the same regslv/snapshot chain. Round-robin grant; one transaction outstanding at a time.
//  Request fields are registered, so the downstream side sees stable addr/data for the whole handshake.
// PARAMETERS
//  NUM_MST         2     number of upstream masters (>=2)
//  ADDR_WIDTH      64    reg_native_if address width
//  DATA_WIDTH      32    reg_native_if data width
//  TIMEOUT_CYCLES  1024  ack watchdog limit in cycles (used only with REG_ARB_TIMEOUT_EN)
// PORTS
//  clk             in   1                    clock; single clock domain
//  rst             in   1                    asynchronous, active-high reset
//  up_req_vld      in   NUM_MST              per-master request valid
//  up_req_rdy      out  NUM_MST              per-master request accepted
//  up_wr_en        in   NUM_MST              per-master write strobe
//  up_rd_en        in   NUM_MST              per-master read strobe
//  up_addr         in   NUM_MST*ADDR_WIDTH   flattened addresses; master i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//  up_wr_data      in   NUM_MST*DATA_WIDTH   flattened write data
//  up_ack_vld      out  NUM_MST              per-master ack valid
//  up_ack_rdy      in   NUM_MST              per-master ack ready
//  up_rd_data      out  DATA_WIDTH           read data, shared; valid with up_ack_vld[grant]
//  dn_req_vld      out  1                    downstream reg_native_if request
//  dn_req_rdy      in   1                    downstream request ready
//  dn_wr_en, dn_rd_en  out  1                downstream strobes (registered)
//  dn_addr         out  ADDR_WIDTH           registered address
//  dn_wr_data      out  DATA_WIDTH           registered write data
//  dn_ack_vld      in   1                    downstream ack valid
//  dn_ack_rdy      out  1                    downstream ack ready
//  dn_rd_data      in   DATA_WIDTH           downstream read data
//  arb_timeout     out  1                    one-cycle pulse on watchdog abort (tied 0 without the macro)
// BEHAVIOUR
//  Reset values: state=IDLE, rr_ptr=0, grant=0, all vld/rdy outputs 0, dn_addr/dn_wr_data/up_rd_data 0.
//  FSM IDLE -> REQ -> ACK -> IDLE.
//  IDLE: the winner is the first master with up_req_vld set, searching from rr_ptr upward with wrap.
//    up_req_rdy[winner]=1 combinationally in the same cycle, and that cycle is the accept.
//    On accept: latch grant, addr, wr_data and strobes, then go to REQ.
//    up_req_rdy is 0 in every state other than IDLE.
//  REQ: dn_req_vld=1 with the latched fields. On dn_req_rdy go to ACK.
//    Latency from accept to dn_req_vld is 1 cycle.
//  ACK: up_ack_vld[grant]=dn_ack_vld; dn_ack_rdy=up_ack_rdy[grant]; up_rd_data=dn_rd_data.
//    When dn_ack_vld and dn_ack_rdy are both 1: go to IDLE and set rr_ptr=(grant+1) mod NUM_MST.
//  Back-to-back: a request pending during the ack cycle is accepted on the next cycle (IDLE).
//    Minimum spacing is 3 cycles per transaction.
//  Fairness: a master holding up_req_vld continuously is granted within NUM_MST transactions.
//  Both wr_en and rd_en set: forwarded as a write; dn_rd_en is forced to 0.
//  Strobes: a request with neither strobe set is still forwarded unchanged.
//  Masking: non-granted up_ack_vld bits are always 0.
//  Spurious ack: dn_ack_vld in IDLE or REQ is ignored and dn_ack_rdy stays 0.
//  Reset asserted mid-transaction: immediate return to IDLE and all handshakes drop.
//    A downstream ack that is already in flight after reset is ignored.
// CONFIGURATION
//  REG_ARB_TIMEOUT_EN defined:
//    - A counter runs in REQ and ACK.
//    - When it reaches TIMEOUT_CYCLES: drop dn_req_vld, drive up_ack_vld[grant]=1 with up_rd_data=0 until up_ack_rdy.
//    - arb_timeout pulses for 1 cycle, then the FSM returns to IDLE and advances rr_ptr.
//    - The counter clears on every state change.
//  REG_ARB_TIMEOUT_EN undefined: no counter; arb_timeout is tied 0; the arbiter waits indefinitely.
// STRUCTURE
//  Package reg_arb_pkg:
//    - arb_state_e enum {IDLE, REQ, ACK, TOUT}; TOUT exists only with the macro.
//    - Localparam helper for the width of the grant index, $clog2(NUM_MST).
//  Sub-module rr_pick:
//    - Combinational round-robin priority picker.
//    - Inputs: req vector and ptr. Outputs: onehot grant, grant index, any.
//  All FSM, latch and watchdog logic stays in reg_native_arbiter.
// TESTING
//  1. Single master, NUM_MST=2: m0 writes addr=0x10, data=0x1111_1111, downstream rdy immediately.
//     -> dn_req_vld 1 cycle after accept, dn_addr=0x10, dn_wr_en=1; up_ack_vld=2'b01.
//  2. m0 and m1 request in the same cycle after reset.
//     -> m0 is served first, then m1, then m0 again if still requesting; no grant repeats while the other is waiting.
//  3. m1 reads 0x20 while downstream stalls dn_req_rdy for 5 cycles and returns rd_data=0xAAAA_AAAA.
//     -> dn_addr stays stable throughout; up_ack_vld[1]=1 with up_rd_data=0xAAAA_AAAA; up_req_rdy[0]=0 meanwhile.
//  4. up_ack_rdy held low for 3 cycles.
//     -> dn_ack_rdy stays low; the FSM holds ACK; a new request is accepted the cycle after the ack completes.
//  5. rst pulsed while in REQ.
//     -> all outputs return to reset values asynchronously; the next request is granted to m0.
//  6. (REG_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16) Downstream never acks.
//     -> arb_timeout pulses after 16 cycles; up_ack_vld with rd_data=0; the next master is then served.

Source files
------------

// File: rtl/reg_native_arbiter_pkg.sv
// Shared types and helpers for the reg_native_if arbiter.
// Optional feature macro: REG_ARB_TIMEOUT_EN adds the TOUT (watchdog abort) state.
package reg_arb_pkg;

  // Arbiter FSM states; TOUT is only reachable when the ack watchdog is built in.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2
`ifdef REG_ARB_TIMEOUT_EN
    ,
    TOUT = 2'd3
`endif
  } arb_state_e;

  // Width of a master index; never narrower than one bit.
  function automatic int idx_width(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/reg_native_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping
// back to index 0. Returns a onehot grant, its index and an any-request flag.
module rr_pick
  import reg_arb_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Walk the request vector starting at ptr; the first hit wins and masks the rest.
  always_comb begin
    int   j;
    logic hit;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    hit = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      j = (j >= N) ? (j - N) : j;
      hit    = req[j] & ~any;
      gnt[j] = hit;
      idx    = hit ? IW'(j) : idx;
      any    = any | hit;
    end
  end

endmodule

// File: rtl/reg_native_arbiter.sv
// reg_native_arbiter: shares one downstream reg_native_if between NUM_MST
// upstream masters. Round-robin grant, one transaction outstanding, request
// fields registered so downstream sees stable addr/data for the whole handshake.
// Optional macro REG_ARB_TIMEOUT_EN: ack watchdog that aborts a transaction after
// TIMEOUT_CYCLES in REQ/ACK, answering the master with rd_data=0 and pulsing
// arb_timeout. Without it arb_timeout is tied 0 and the arbiter waits forever.
module reg_native_arbiter
  import reg_arb_pkg::*;
#(
  parameter int NUM_MST        = 2,
  parameter int ADDR_WIDTH     = 64,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_MST-1:0]              up_req_vld,
  output logic [NUM_MST-1:0]              up_req_rdy,
  input  logic [NUM_MST-1:0]              up_wr_en,
  input  logic [NUM_MST-1:0]              up_rd_en,
  input  logic [NUM_MST*ADDR_WIDTH-1:0]   up_addr,
  input  logic [NUM_MST*DATA_WIDTH-1:0]   up_wr_data,
  output logic [NUM_MST-1:0]              up_ack_vld,
  input  logic [NUM_MST-1:0]              up_ack_rdy,
  output logic [DATA_WIDTH-1:0]           up_rd_data,
  output logic                            dn_req_vld,
  input  logic                            dn_req_rdy,
  output logic                            dn_wr_en,
  output logic                            dn_rd_en,
  output logic [ADDR_WIDTH-1:0]           dn_addr,
  output logic [DATA_WIDTH-1:0]           dn_wr_data,
  input  logic                            dn_ack_vld,
  output logic                            dn_ack_rdy,
  input  logic [DATA_WIDTH-1:0]           dn_rd_data,
  output logic                            arb_timeout
);

  localparam int            IW       = idx_width(NUM_MST);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_MST - 1);

  arb_state_e          state_r;
  logic [IW-1:0]       grant_r;
  logic [IW-1:0]       rr_ptr_r;
  logic [IW-1:0]       next_ptr_s;
  logic [NUM_MST-1:0]  grant_oh_s;
  logic [NUM_MST-1:0]  pick_gnt_s;
  logic [IW-1:0]       pick_idx_s;
  logic                pick_any_s;
  logic                accept_s;
  logic                ack_done_s;
  logic                sel_wr_s;
  logic                sel_rd_s;
  logic [ADDR_WIDTH-1:0] sel_addr_s;
  logic [DATA_WIDTH-1:0] sel_wdata_s;

  rr_pick #(
    .N  (NUM_MST),
    .IW (IW)
  ) u_pick (
    .req (up_req_vld),
    .ptr (rr_ptr_r),
    .gnt (pick_gnt_s),
    .idx (pick_idx_s),
    .any (pick_any_s)
  );

  // Select the winning master's fields; a request with both strobes is a write.
  always_comb begin
    sel_wr_s    = up_wr_en[pick_idx_s];
    sel_rd_s    = up_rd_en[pick_idx_s] & ~up_wr_en[pick_idx_s];
    sel_addr_s  = up_addr[int'(pick_idx_s)*ADDR_WIDTH +: ADDR_WIDTH];
    sel_wdata_s = up_wr_data[int'(pick_idx_s)*DATA_WIDTH +: DATA_WIDTH];
    next_ptr_s  = (grant_r == LAST_IDX) ? '0 : (grant_r + IW'(1));
    grant_oh_s  = '0;
    grant_oh_s[grant_r] = 1'b1;
  end

  // Upstream/downstream handshake steering; everything is masked to the granted
  // master, and spurious downstream acks outside ACK are never acknowledged.
  always_comb begin
    up_req_rdy = '0;
    up_ack_vld = '0;
    dn_ack_rdy = 1'b0;
    up_rd_data = '0;
    case (state_r)
      IDLE: begin
        up_req_rdy = rst ? '0 : pick_gnt_s;
      end
      REQ: begin
        up_req_rdy = '0;
      end
      ACK: begin
        up_ack_vld = dn_ack_vld ? grant_oh_s : '0;
        dn_ack_rdy = up_ack_rdy[grant_r];
        up_rd_data = dn_rd_data;
      end
`ifdef REG_ARB_TIMEOUT_EN
      TOUT: begin
        up_ack_vld = grant_oh_s;
        up_rd_data = '0;
      end
`endif
      default: begin
        up_req_rdy = '0;
      end
    endcase
    accept_s   = (state_r == IDLE) && pick_any_s && !rst;
    ack_done_s = (state_r == ACK) && dn_ack_vld && up_ack_rdy[grant_r];
  end

`ifdef REG_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] to_cnt_r;
  logic          to_hit_s;

  // Watchdog limit reached on the last counted cycle of REQ or ACK.
  always_comb begin
    to_hit_s = (to_cnt_r == CW'(TIMEOUT_CYCLES - 1));
  end
`else
  assign arb_timeout = 1'b0;
`endif

  // Arbiter FSM with registered downstream request fields and grant bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      grant_r    <= '0;
      rr_ptr_r   <= '0;
      dn_req_vld <= 1'b0;
      dn_wr_en   <= 1'b0;
      dn_rd_en   <= 1'b0;
      dn_addr    <= '0;
      dn_wr_data <= '0;
`ifdef REG_ARB_TIMEOUT_EN
      to_cnt_r    <= '0;
      arb_timeout <= 1'b0;
`endif
    end else begin
`ifdef REG_ARB_TIMEOUT_EN
      arb_timeout <= 1'b0;
`endif
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            state_r    <= REQ;
            grant_r    <= pick_idx_s;
            dn_req_vld <= 1'b1;
            dn_wr_en   <= sel_wr_s;
            dn_rd_en   <= sel_rd_s;
            dn_addr    <= sel_addr_s;
            dn_wr_data <= sel_wdata_s;
          end else begin
            state_r <= IDLE;
          end
        end
        REQ: begin
          if (dn_req_rdy) begin
            state_r    <= ACK;
            dn_req_vld <= 1'b0;
`ifdef REG_ARB_TIMEOUT_EN
            to_cnt_r   <= '0;
          end else if (to_hit_s) begin
            state_r     <= TOUT;
            dn_req_vld  <= 1'b0;
            arb_timeout <= 1'b1;
            to_cnt_r    <= '0;
          end else begin
            to_cnt_r <= to_cnt_r + CW'(1);
`else
          end else begin
            state_r <= REQ;
`endif
          end
        end
        ACK: begin
          if (ack_done_s) begin
            state_r  <= IDLE;
            rr_ptr_r <= next_ptr_s;
`ifdef REG_ARB_TIMEOUT_EN
            to_cnt_r <= '0;
          end else if (to_hit_s) begin
            state_r     <= TOUT;
            arb_timeout <= 1'b1;
            to_cnt_r    <= '0;
          end else begin
            to_cnt_r <= to_cnt_r + CW'(1);
`else
          end else begin
            state_r <= ACK;
`endif
          end
        end
`ifdef REG_ARB_TIMEOUT_EN
        TOUT: begin
          if (up_ack_rdy[grant_r]) begin
            state_r  <= IDLE;
            rr_ptr_r <= next_ptr_s;
          end else begin
            state_r <= TOUT;
          end
        end
`endif
        default: begin
          state_r    <= IDLE;
          dn_req_vld <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_native_arbiter.sv
// Directed self-checking bench for reg_native_arbiter (NUM_MST=2).
// Downstream request fields and read data are predicted into scoreboard queues
// when stimulus is driven and compared when the DUT presents them.
module tb_reg_native_arbiter;

  localparam int NM = 2;
  localparam int AW = 64;
  localparam int DW = 32;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [NM-1:0]  up_req_vld;
  logic [NM-1:0]  up_req_rdy;
  logic [NM-1:0]  up_wr_en;
  logic [NM-1:0]  up_rd_en;
  logic [NM*AW-1:0] up_addr;
  logic [NM*DW-1:0] up_wr_data;
  logic [NM-1:0]  up_ack_vld;
  logic [NM-1:0]  up_ack_rdy;
  logic [DW-1:0]  up_rd_data;
  logic           dn_req_vld;
  logic           dn_req_rdy;
  logic           dn_wr_en;
  logic           dn_rd_en;
  logic [AW-1:0]  dn_addr;
  logic [DW-1:0]  dn_wr_data;
  logic           dn_ack_vld;
  logic           dn_ack_rdy;
  logic [DW-1:0]  dn_rd_data;
  logic           arb_timeout;

  logic [AW-1:0]  m_addr [NM];
  logic [DW-1:0]  m_wd   [NM];

  assign up_addr    = {m_addr[1], m_addr[0]};
  assign up_wr_data = {m_wd[1], m_wd[0]};

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    logic          wr;
    logic          rd;
  } dn_exp_t;

  dn_exp_t       dn_q [$];
  logic [DW-1:0] rd_q [$];

  int vectors     = 0;
  int miscompares = 0;

  reg_native_arbiter #(
    .NUM_MST        (NM),
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .up_req_vld  (up_req_vld),
    .up_req_rdy  (up_req_rdy),
    .up_wr_en    (up_wr_en),
    .up_rd_en    (up_rd_en),
    .up_addr     (up_addr),
    .up_wr_data  (up_wr_data),
    .up_ack_vld  (up_ack_vld),
    .up_ack_rdy  (up_ack_rdy),
    .up_rd_data  (up_rd_data),
    .dn_req_vld  (dn_req_vld),
    .dn_req_rdy  (dn_req_rdy),
    .dn_wr_en    (dn_wr_en),
    .dn_rd_en    (dn_rd_en),
    .dn_addr     (dn_addr),
    .dn_wr_data  (dn_wr_data),
    .dn_ack_vld  (dn_ack_vld),
    .dn_ack_rdy  (dn_ack_rdy),
    .dn_rd_data  (dn_rd_data),
    .arb_timeout (arb_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] oh(input int m);
    logic [1:0] r;
    r    = 2'b00;
    r[m] = 1'b1;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_mst(input int m, input logic wr, input logic rd,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    up_wr_en[m] = wr;
    up_rd_en[m] = rd;
    m_addr[m]   = a;
    m_wd[m]     = d;
  endtask

  task automatic push_req(input int m);
    dn_exp_t e;
    e.addr = m_addr[m];
    e.wd   = m_wd[m];
    e.wr   = up_wr_en[m];
    e.rd   = up_rd_en[m] & ~up_wr_en[m];
    dn_q.push_back(e);
  endtask

  task automatic check_dn(input string tag);
    dn_exp_t e;
    check({tag, ".sb_dn"}, 64'(dn_q.size() > 0), 64'd1);
    if (dn_q.size() > 0) begin
      e = dn_q.pop_front();
      check({tag, ".dn_addr"}, dn_addr, e.addr);
      check({tag, ".dn_wr_data"}, 64'(dn_wr_data), 64'(e.wd));
      check({tag, ".dn_wr_en"}, 64'(dn_wr_en), 64'(e.wr));
      check({tag, ".dn_rd_en"}, 64'(dn_rd_en), 64'(e.rd));
    end
  endtask

  // One full transaction: accept in IDLE, optional REQ stall with spurious acks,
  // optional upstream ack back-pressure, then completion.
  task automatic do_txn(input logic [1:0] req_vec, input int m, input int stall,
                        input logic [DW-1:0] rdata, input int ack_stall, input string tag);
    logic [1:0]    ohm;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_rd;
    ohm      = oh(m);
    exp_addr = m_addr[m];
    up_req_vld = req_vec;
    push_req(m);
    #1;
    check({tag, ".req_rdy"}, 64'(up_req_rdy), 64'(ohm));
    tick();
    up_req_vld[m] = 1'b0;
    #1;
    check({tag, ".dn_req_vld"}, 64'(dn_req_vld), 64'd1);
    check({tag, ".req_rdy_busy"}, 64'(up_req_rdy), 64'd0);
    check_dn(tag);
    for (int i = 0; i < stall; i++) begin
      dn_ack_vld = 1'b1;
      #1;
      check({tag, ".stall_vld"}, 64'(dn_req_vld), 64'd1);
      check({tag, ".stall_addr"}, dn_addr, exp_addr);
      check({tag, ".stall_req_rdy"}, 64'(up_req_rdy), 64'd0);
      check({tag, ".spur_ack_rdy"}, 64'(dn_ack_rdy), 64'd0);
      check({tag, ".spur_ack_vld"}, 64'(up_ack_vld), 64'd0);
      tick();
    end
    dn_ack_vld = 1'b0;
    dn_req_rdy = 1'b1;
    tick();
    dn_req_rdy = 1'b0;
    #1;
    check({tag, ".dn_req_drop"}, 64'(dn_req_vld), 64'd0);
    rd_q.push_back(rdata);
    dn_rd_data = rdata;
    dn_ack_vld = 1'b1;
    for (int i = 0; i < ack_stall; i++) begin
      up_ack_rdy = ~ohm;
      #1;
      check({tag, ".bp_dn_ack_rdy"}, 64'(dn_ack_rdy), 64'd0);
      check({tag, ".bp_ack_vld"}, 64'(up_ack_vld), 64'(ohm));
      tick();
    end
    up_ack_rdy = ohm;
    #1;
    check({tag, ".dn_ack_rdy"}, 64'(dn_ack_rdy), 64'd1);
    check({tag, ".up_ack_vld"}, 64'(up_ack_vld), 64'(ohm));
    check({tag, ".sb_rd"}, 64'(rd_q.size() > 0), 64'd1);
    if (rd_q.size() > 0) begin
      exp_rd = rd_q.pop_front();
      check({tag, ".up_rd_data"}, 64'(up_rd_data), 64'(exp_rd));
    end
    tick();
    dn_ack_vld = 1'b0;
    up_ack_rdy = 2'b00;
    dn_rd_data = '0;
    #1;
    check({tag, ".ack_clear"}, 64'(up_ack_vld), 64'd0);
    check({tag, ".no_timeout"}, 64'(arb_timeout), 64'd0);
  endtask

  // Global time bound so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Directed stimulus sequence.
  initial begin
    rst        = 1'b0;
    up_req_vld = 2'b11;
    up_wr_en   = 2'b00;
    up_rd_en   = 2'b00;
    up_ack_rdy = 2'b00;
    dn_req_rdy = 1'b0;
    dn_ack_vld = 1'b0;
    dn_rd_data = '0;
    m_addr[0]  = '0;
    m_addr[1]  = '0;
    m_wd[0]    = '0;
    m_wd[1]    = '0;
    #1 rst = 1'b1;
    #2;
    check("rst.dn_req_vld", 64'(dn_req_vld), 64'd0);
    check("rst.up_req_rdy", 64'(up_req_rdy), 64'd0);
    check("rst.up_ack_vld", 64'(up_ack_vld), 64'd0);
    check("rst.dn_addr", dn_addr, 64'd0);
    check("rst.dn_wr_data", 64'(dn_wr_data), 64'd0);
    check("rst.up_rd_data", 64'(up_rd_data), 64'd0);
    check("rst.arb_timeout", 64'(arb_timeout), 64'd0);
    up_req_vld = 2'b00;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Both masters request together: m0, m1, m0 in turn.
    set_mst(0, 1'b1, 1'b0, 64'h10, 32'h1111_1111);
    set_mst(1, 1'b0, 1'b1, 64'h20, 32'h0);
    do_txn(2'b11, 0, 0, 32'h0000_0001, 0, "t2a");
    do_txn(2'b11, 1, 0, 32'h0000_0002, 0, "t2b");
    do_txn(2'b11, 0, 0, 32'h0000_0003, 0, "t2c");

    // Single master write, downstream ready immediately.
    do_txn(2'b01, 0, 0, 32'h0, 0, "t1");

    // m1 read with a 5-cycle downstream stall while m0 also waits.
    set_mst(1, 1'b0, 1'b1, 64'h20, 32'h0);
    do_txn(2'b11, 1, 5, 32'hAAAA_AAAA, 0, "t3");

    // Upstream ack back-pressure, both strobes, then back-to-back no-strobe request.
    set_mst(0, 1'b1, 1'b1, 64'h30, 32'h3333_3333);
    set_mst(1, 1'b0, 1'b0, 64'h50, 32'h5555_5555);
    do_txn(2'b01, 0, 0, 32'hC0DE_0004, 3, "t4a");
    do_txn(2'b10, 1, 0, 32'hC0DE_0005, 0, "t4b");

    // Spurious ack in IDLE is ignored.
    dn_ack_vld = 1'b1;
    #1;
    check("idle.spur_ack_rdy", 64'(dn_ack_rdy), 64'd0);
    check("idle.spur_ack_vld", 64'(up_ack_vld), 64'd0);
    dn_ack_vld = 1'b0;
    tick();

    // Finish an m0 transaction so the pointer favours m1, then reset mid-REQ.
    set_mst(0, 1'b1, 1'b0, 64'h40, 32'h4444_4444);
    do_txn(2'b01, 0, 0, 32'h0, 0, "t5pre");
    up_req_vld = 2'b01;
    push_req(0);
    #1;
    check("t5.req_rdy", 64'(up_req_rdy), 64'd1);
    tick();
    up_req_vld = 2'b11;
    #1;
    check("t5.dn_req_vld", 64'(dn_req_vld), 64'd1);
    check_dn("t5");
    #1 rst = 1'b1;
    dn_ack_vld = 1'b1;
    #1;
    check("t5.rst_dn_req_vld", 64'(dn_req_vld), 64'd0);
    check("t5.rst_dn_addr", dn_addr, 64'd0);
    check("t5.rst_dn_wr_en", 64'(dn_wr_en), 64'd0);
    check("t5.rst_req_rdy", 64'(up_req_rdy), 64'd0);
    check("t5.rst_ack_rdy", 64'(dn_ack_rdy), 64'd0);
    check("t5.rst_ack_vld", 64'(up_ack_vld), 64'd0);
    up_req_vld = 2'b00;
    tick();
    rst = 1'b0;
    #1;
    check("t5.late_ack_rdy", 64'(dn_ack_rdy), 64'd0);
    check("t5.late_ack_vld", 64'(up_ack_vld), 64'd0);
    tick();
    dn_ack_vld = 1'b0;
    do_txn(2'b11, 0, 0, 32'h0000_0006, 0, "t5post_m0");
    do_txn(2'b10, 1, 0, 32'h0000_0007, 0, "t5post_m1");

    // Downstream accepts the request but never acks.
    up_req_vld = 2'b01;
    push_req(0);
    #1;
    check("t6.req_rdy", 64'(up_req_rdy), 64'd1);
    tick();
    up_req_vld = 2'b00;
    check_dn("t6");
    dn_req_rdy = 1'b1;
    tick();
    dn_req_rdy = 1'b0;
    dn_rd_data = 32'hDEAD_BEEF;
`ifdef REG_ARB_TIMEOUT_EN
    for (int i = 0; i < TO - 1; i++) begin
      tick();
      check("t6.pre_timeout", 64'(arb_timeout), 64'd0);
    end
    tick();
    check("t6.timeout_pulse", 64'(arb_timeout), 64'd1);
    check("t6.tout_ack_vld", 64'(up_ack_vld), 64'd1);
    check("t6.tout_rd_data", 64'(up_rd_data), 64'd0);
    check("t6.tout_dn_req_vld", 64'(dn_req_vld), 64'd0);
    check("t6.tout_dn_ack_rdy", 64'(dn_ack_rdy), 64'd0);
    tick();
    check("t6.pulse_end", 64'(arb_timeout), 64'd0);
    check("t6.tout_hold", 64'(up_ack_vld), 64'd1);
    up_ack_rdy = 2'b01;
    tick();
    up_ack_rdy = 2'b00;
`else
    for (int i = 0; i < TO + 4; i++) begin
      tick();
      check("t6.no_timeout", 64'(arb_timeout), 64'd0);
      check("t6.wait_ack_vld", 64'(up_ack_vld), 64'd0);
    end
    dn_ack_vld = 1'b1;
    up_ack_rdy = 2'b01;
    #1;
    check("t6.late_ack_vld", 64'(up_ack_vld), 64'd1);
    check("t6.late_rd_data", 64'(up_rd_data), 64'hDEAD_BEEF);
    tick();
    dn_ack_vld = 1'b0;
    up_ack_rdy = 2'b00;
`endif
    dn_rd_data = '0;
    #1;
    check("t6.done_ack_vld", 64'(up_ack_vld), 64'd0);
    do_txn(2'b11, 1, 0, 32'h0000_0008, 0, "t6next");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
